// File: rtl/multi_reader_fifo_if.sv
// -----------------------------------------------------------------------------
// multi_reader_fifo_if
// Bundles the request and status signals of multi_reader_fifo.
//   master : the producer/consumer side (drives Push/DataIn/Pop/Flush,
//            observes data and status)
//   slave  : the FIFO itself
// Signals:
//   Push       write request
//   DataIn     write data
//   Pop        per-reader pop request, bit i = reader i
//   Flush      synchronous clear of all pointers and sticky flags
//   DataOut    reader i head data at [i*DataWidth +: DataWidth]
//   Empty      bit i set when reader i has nothing unread
//   Full       no free entry (slowest reader lags by BufferSize)
//   Level      unread count per reader at [i*(BufferWidth+1) +: BufferWidth+1]
//   Valid      bit k set when entry k is still unread by some reader
//   Overflow   sticky, Push seen while Full
//   Underflow  sticky, Pop[i] seen while Empty[i]
// -----------------------------------------------------------------------------
interface multi_reader_fifo_if #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4,
  parameter int NumReaders  = 2
) ();

  logic                                  Push;
  logic [DataWidth-1:0]                  DataIn;
  logic [NumReaders-1:0]                 Pop;
  logic                                  Flush;
  logic [NumReaders*DataWidth-1:0]       DataOut;
  logic [NumReaders-1:0]                 Empty;
  logic                                  Full;
  logic [NumReaders*(BufferWidth+1)-1:0] Level;
  logic [BufferSize-1:0]                 Valid;
  logic                                  Overflow;
  logic                                  Underflow;

  modport master (
    output Push, DataIn, Pop, Flush,
    input  DataOut, Empty, Full, Level, Valid, Overflow, Underflow
  );

  modport slave (
    input  Push, DataIn, Pop, Flush,
    output DataOut, Empty, Full, Level, Valid, Overflow, Underflow
  );

endinterface

// File: rtl/multi_reader_fifo.sv
// -----------------------------------------------------------------------------
// multi_reader_fifo
// Single-writer FIFO with NumReaders independent read pointers. An entry is
// freed only once every reader has popped it. Status (Empty/Full/Level/Valid)
// is derived combinationally from the registered pointers; reads are
// first-word fall-through.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset (clears pointers, flags and memory)
//   bus  multi_reader_fifo_if.slave; see the interface file for the signals
// BufferSize must equal 2**BufferWidth and BufferWidth must be at least 1.
// -----------------------------------------------------------------------------
module multi_reader_fifo #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4,
  parameter int NumReaders  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_reader_fifo_if.slave   bus
);

  // Pointers carry one extra round bit so that full and empty differ.
  localparam int              PW    = BufferWidth + 1;
  localparam logic [PW-1:0]   DEPTH = PW'(BufferSize);

  logic [DataWidth-1:0] mem_q  [BufferSize];
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q [NumReaders];
  logic [PW-1:0]        rptr_d [NumReaders];
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [PW-1:0]         level    [NumReaders];
  logic [NumReaders-1:0] empty_vec;
  logic                  full;
  logic                  wr_en;

  // ---------------------------------------------------------------------------
  // Per-reader occupancy: modular difference of the full-width pointers
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NumReaders; gi++) begin : g_level
      assign level[gi] = wptr_q - rptr_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Status and read data
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [NumReaders*DataWidth-1:0] dout;
    logic [NumReaders*PW-1:0]        lvl;
    logic [BufferSize-1:0]           valid;

    empty_vec = '0;
    full      = 1'b0;
    dout      = '0;
    lvl       = '0;
    valid     = '0;

    for (int i = 0; i < NumReaders; i++) begin
      empty_vec[i]          = (level[i] == '0);
      // Full follows the slowest reader, i.e. the largest level.
      full                  = full | (level[i] == DEPTH);
      lvl[i*PW +: PW]       = level[i];
      dout[i*DataWidth +: DataWidth] = mem_q[rptr_q[i][BufferWidth-1:0]];

      // Entry k is unread by reader i when its distance from the read
      // address (mod BufferSize) is below the reader's level. A level of
      // BufferSize covers every slot, which resolves the equal-address case.
      for (int k = 0; k < BufferSize; k++) begin
        if (PW'(BufferWidth'(BufferWidth'(k) - rptr_q[i][BufferWidth-1:0])) < level[i]) begin
          valid[k] = 1'b1;
        end
      end
    end

    bus.DataOut   = dout;
    bus.Level     = lvl;
    bus.Valid     = valid;
    bus.Empty     = empty_vec;
    bus.Full      = full;
    bus.Overflow  = overflow_q;
    bus.Underflow = underflow_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state: Full/Empty are judged on the pre-edge pointers, so a push
  // into a full FIFO is refused even if the slowest reader pops this cycle,
  // and a pop from an empty reader is refused even if a push lands now.
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d      = wptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    for (int i = 0; i < NumReaders; i++) begin
      rptr_d[i] = rptr_q[i];
    end

    if (bus.Flush) begin
      // Flush wins over Push/Pop; a dropped Push does not count as overflow.
      wptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      for (int i = 0; i < NumReaders; i++) begin
        rptr_d[i] = '0;
      end
    end else begin
      if (bus.Push) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + PW'(1);
        end
      end
      for (int i = 0; i < NumReaders; i++) begin
        if (bus.Pop[i]) begin
          if (empty_vec[i]) begin
            underflow_d = 1'b1;
          end else begin
            rptr_d[i] = rptr_q[i] + PW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < NumReaders; i++) begin
        rptr_q[i] <= '0;
      end
    end else begin
      wptr_q      <= wptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < NumReaders; i++) begin
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: cleared by reset so DataOut reads zero while in reset; Flush
  // leaves the contents in place.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BufferSize; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wptr_q[BufferWidth-1:0]] <= bus.DataIn;
    end
  end

endmodule

// File: tb/tb_multi_reader_fifo.sv
module tb_multi_reader_fifo;

  localparam int DW = 32;
  localparam int BW = 2;
  localparam int BS = 4;
  localparam int NR = 2;
  localparam int PW = BW + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_reader_fifo_if #(.DataWidth(DW), .BufferWidth(BW), .BufferSize(BS), .NumReaders(NR)) bus ();

  multi_reader_fifo #(.DataWidth(DW), .BufferWidth(BW), .BufferSize(BS), .NumReaders(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_tx     = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: unbounded write/read counts; an item written as the j-th
  // accepted push lives in slot j % BS. Level is simply writes minus reads.
  int          m_wcnt;
  int          m_rcnt [NR];
  logic [DW-1:0] m_mem [BS];
  bit          m_ovf, m_unf;

  function automatic int m_level(input int i);
    return m_wcnt - m_rcnt[i];
  endfunction

  function automatic bit m_full();
    bit f = 0;
    for (int i = 0; i < NR; i++) if (m_level(i) == BS) f = 1;
    return f;
  endfunction

  task automatic model_reset();
    m_wcnt = 0;
    for (int i = 0; i < NR; i++) m_rcnt[i] = 0;
    for (int k = 0; k < BS; k++) m_mem[k] = '0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit push, input logic [DW-1:0] din, input logic [NR-1:0] pop, input bit flush);
    int  lv [NR];
    bit  full_pre;
    full_pre = m_full();
    for (int i = 0; i < NR; i++) lv[i] = m_level(i);
    if (flush) begin
      m_wcnt = 0;
      for (int i = 0; i < NR; i++) m_rcnt[i] = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (push) begin
        if (full_pre) m_ovf = 1;
        else begin
          m_mem[m_wcnt % BS] = din;
          m_wcnt++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (pop[i]) begin
          if (lv[i] == 0) m_unf = 1;
          else m_rcnt[i]++;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    logic [NR-1:0]    e_empty;
    logic [NR*PW-1:0] e_level;
    logic [NR*DW-1:0] e_dout;
    logic [BS-1:0]    e_valid;
    e_empty = '0; e_level = '0; e_dout = '0; e_valid = '0;
    for (int i = 0; i < NR; i++) begin
      e_empty[i]          = (m_level(i) == 0);
      e_level[i*PW +: PW] = PW'(m_level(i));
      e_dout[i*DW +: DW]  = m_mem[m_rcnt[i] % BS];
      for (int j = m_rcnt[i]; j < m_wcnt; j++) e_valid[j % BS] = 1'b1;
    end
    check_eq({ctx, ".empty"}, 128'(bus.Empty), 128'(e_empty));
    check_eq({ctx, ".full"}, 128'(bus.Full), 128'(m_full()));
    check_eq({ctx, ".level"}, 128'(bus.Level), 128'(e_level));
    check_eq({ctx, ".valid"}, 128'(bus.Valid), 128'(e_valid));
    check_eq({ctx, ".dout"}, 128'(bus.DataOut), 128'(e_dout));
    check_eq({ctx, ".ovf"}, 128'(bus.Overflow), 128'(m_ovf));
    check_eq({ctx, ".unf"}, 128'(bus.Underflow), 128'(m_unf));
  endtask

  task automatic do_cycle(input string ctx, input bit push, input logic [DW-1:0] din,
                          input logic [NR-1:0] pop, input bit flush);
    bus.Push   = push;
    bus.DataIn = din;
    bus.Pop    = pop;
    bus.Flush  = flush;
    @(posedge clk);
    model_step(push, din, pop, flush);
    #1;
    n_tx++;
    $display("tx %0d %s push=%0b din=%h pop=%b flush=%0b lvl=%0d/%0d", n_tx, ctx, push, din, pop, flush,
             m_level(0), m_level(1));
    check_all(ctx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    bus.Push   = 1'b0;
    bus.DataIn = '0;
    bus.Pop    = '0;
    bus.Flush  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check_eq("reset.empty_const", 128'(bus.Empty), 128'(2'b11));
    rst = 1'b1;

    // Fill and overflow
    do_cycle("idle", 0, '0, 2'b00, 0);
    do_cycle("fill", 1, 32'hA, 2'b00, 0);
    check_eq("first_word_r0", 128'(bus.DataOut[0 +: DW]), 128'(32'hA));
    check_eq("first_word_r1", 128'(bus.DataOut[DW +: DW]), 128'(32'hA));
    do_cycle("fill", 1, 32'hB, 2'b00, 0);
    do_cycle("fill", 1, 32'hC, 2'b00, 0);
    do_cycle("fill", 1, 32'hD, 2'b00, 0);
    check_eq("full_const", 128'(bus.Full), 128'(1'b1));
    check_eq("full_valid_const", 128'(bus.Valid), 128'(4'hF));
    do_cycle("ovf", 1, 32'hE, 2'b00, 0);
    check_eq("ovf_const", 128'(bus.Overflow), 128'(1'b1));

    // Reader 0 drains while reader 1 keeps FIFO full
    for (int n = 0; n < 4; n++) do_cycle("r0pop", 0, '0, 2'b01, 0);
    check_eq("r0_drained_full", 128'(bus.Full), 128'(1'b1));
    do_cycle("r0unf", 0, '0, 2'b01, 0);
    check_eq("unf_const", 128'(bus.Underflow), 128'(1'b1));
    do_cycle("r1pop", 0, '0, 2'b10, 0);
    check_eq("valid_1110", 128'(bus.Valid), 128'(4'b1110));
    do_cycle("wrap", 1, 32'hE, 2'b00, 0);
    check_eq("wrap_valid", 128'(bus.Valid), 128'(4'hF));
    do_cycle("drain", 0, '0, 2'b11, 0);
    for (int n = 0; n < 3; n++) do_cycle("drain", 0, '0, 2'b10, 0);

    // Same-cycle push and pop on empty
    do_cycle("flush", 0, '0, 2'b00, 1);
    do_cycle("pp_empty", 1, 32'h5, 2'b11, 0);
    check_eq("pp_empty_unf", 128'(bus.Underflow), 128'(1'b1));
    do_cycle("pp_r0", 1, 32'h6, 2'b01, 0);

    // Flush with concurrent push
    do_cycle("flush", 0, '0, 2'b00, 1);
    for (int n = 0; n < 3; n++) do_cycle("fill3", 1, 32'h100 + n, 2'b00, 0);
    do_cycle("flush_push", 1, 32'h777, 2'b00, 1);
    check_eq("flush_push_ovf", 128'(bus.Overflow), 128'(1'b0));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit            p  = ($urandom_range(0, 99) < 55);
      logic [NR-1:0] pp = '0;
      bit            f  = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NR; i++) pp[i] = ($urandom_range(0, 99) < 40);
      do_cycle("rand", p, $urandom, pp, f);
    end

    // Asynchronous reset in the middle of a burst
    for (int n = 0; n < 3; n++) do_cycle("burst", 1, $urandom, 2'b00, 0);
    bus.Push   = 1'b1;
    bus.DataIn = 32'hDEAD;
    @(posedge clk);
    model_step(1, 32'hDEAD, 2'b00, 0);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    $display("tx async reset asserted between edges");
    check_all("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    bus.Push = 1'b0;
    rst      = 1'b1;
    do_cycle("post_rst", 0, '0, 2'b00, 0);
    do_cycle("post_rst", 1, 32'h1234, 2'b00, 0);
    do_cycle("post_rst", 0, '0, 2'b11, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_reader_fifo.md
Name: multi_reader_fifo

Overview:
Parametrised successor of the two-reader weight/input FIFO used in the MAC datapath. It keeps one write pointer and NumReaders independent read pointers. An entry is freed only after every reader has popped it. Depth, width and reader count are generic; Full, Empty and occupancy are derived from pointer arithmetic rather than hard-wired to 4 entries. It also adds flush, per-reader levels and sticky overflow/underflow flags.

Parameters:
DataWidth, 32, bits per entry
BufferWidth, 2, address bits; BufferSize must equal 2**BufferWidth
BufferSize, 4, number of entries
NumReaders, 2, number of independent read ports (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
Push  input  1  write request
DataIn  input  DataWidth  write data
Pop  input  NumReaders  per-reader pop request; bit i = reader i
Flush  input  1  synchronous clear of all pointers and flags
DataOut  output  NumReaders*DataWidth  reader i head data at bits [i*DataWidth +: DataWidth]
Empty  output  NumReaders  bit i set when reader i has no unread entry
Full  output  1  no free entry (slowest reader lags by BufferSize)
Level  output  NumReaders*(BufferWidth+1)  unread count per reader, 0..BufferSize
Valid  output  BufferSize  bit k set when entry k is unread by at least one reader
Overflow  output  1  sticky: Push seen while Full
Underflow  output  1  sticky: any Pop[i] seen while Empty[i]

Behaviour:
- Pointers are BufferWidth+1 bits: WPtr and RPtr[i]. The MSB is the wrap (round) bit; the low bits address memory.
- Level[i] = WPtr - RPtr[i], computed modulo 2**(BufferWidth+1).
- Empty[i] = (Level[i]==0). Full = (max Level == BufferSize). All three are combinational from registered pointers.
- Valid[k] = OR over i of: k lies in the half-open range [RPtr[i], WPtr) modulo BufferSize, with the round bit resolving the case where the two addresses are equal.
- Write: when Push & ~Full, mem[WPtr] <= DataIn and WPtr increments. When Push & Full, no write, WPtr holds, Overflow <= 1.
- Read: DataOut[i] = mem[RPtr[i]] combinationally (first-word fall-through). It is valid only while ~Empty[i] and holds the stale entry otherwise.
- Pop[i] & ~Empty[i]: RPtr[i] increments. Pop[i] & Empty[i]: ignored, Underflow <= 1.
- Latency: data pushed in cycle t appears on DataOut[i] and clears Empty[i] in cycle t+1.
- Full and Empty are evaluated on pre-edge state:
  - Push while Full is rejected even if the slowest reader pops in the same cycle.
  - Pop[i] while Empty[i] is rejected even if Push occurs in the same cycle.
- Simultaneous accepted Push and Pop[i]: Level[i] is unchanged, and the other readers' levels increment.
- Wrap-around: address bits roll BufferSize-1 -> 0 and the round bit toggles. There is no special casing beyond modular subtraction.
- Readers are fully independent: a fast reader may drain to Empty while a slow reader still holds BufferSize entries, which keeps Full asserted.
- Flush, synchronous, with priority over Push and Pop:
  - WPtr and all RPtr go to 0.
  - Overflow and Underflow clear.
  - Memory contents are retained.
  - A concurrent Push is dropped and does not set Overflow.
- Reset (rst low, asynchronous), with the same values held while rst is low:
  - Pointers to 0 and memory to 0.
  - Empty all 1, Full 0, Level all 0, Valid 0, DataOut all 0, Overflow 0, Underflow 0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle -> Empty=2'b11, Full=0, Level=0/0, Valid=4'b0000, DataOut=0, flags 0.
- Push 0xA,0xB,0xC,0xD on consecutive cycles, no pops -> cycle after first push DataOut0=DataOut1=0xA; after 4 pushes Full=1, Valid=4'b1111, Level=4/4; a 5th Push of 0xE is dropped, Overflow=1, mem unchanged.
- From full, reader 0 pops 4 times -> DataOut0 sequence 0xA,0xB,0xC,0xD; Empty=2'b01; Full stays 1 (Level1=4); Valid stays 4'b1111; the next Pop[0] sets Underflow=1.
- Reader 1 then pops once -> Full=0, Valid=4'b1110. Push 0xE -> written to entry 0 with the round bit toggled, Level=1/4, Valid=4'b1111; both readers drain in order 0xE (r0) and 0xB..0xE (r1) correctly across the wrap.
- Empty FIFO, same-cycle Push 0x5 and Pop=2'b11 -> pops ignored, Underflow=1; next cycle Level=1/1, DataOut0=DataOut1=0x5. Same-cycle Push 0x6 and Pop[0] -> Level=1/2, DataOut0=0x6.
- Level 3/3, assert Flush with Push -> next cycle Empty=2'b11, Level=0/0, flags 0, Overflow stays 0. Separately, drop rst mid-burst -> outputs at reset values without waiting for a clk edge.
